// File: rtl/cpu_alu_if.sv
// Operand/operator bus between the CPU datapath and the registered ALU.
// The master drives operands and selects; the slave (ALU) returns the result and flags.
interface cpu_alu_if #(
    parameter int WIDTH = 16
);
    logic             single;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] value2;
    logic [3:0]       operator;
    logic             carry_in;
    logic [WIDTH-1:0] bus_out;
    logic [4:0]       alu_flags;

    modport master (
        output single, value1, value2, operator, carry_in,
        input  bus_out, alu_flags
    );

    modport slave (
        input  single, value1, value2, operator, carry_in,
        output bus_out, alu_flags
    );
endinterface

// File: rtl/cpu_alu.sv
// 16-bit registered ALU: one-cycle latency, flags {P,V,N,Z,C}.
// Optional multiplier (MUL/MULH) enabled by defining ALU_MUL_EN.
module cpu_alu #(
    parameter int WIDTH = 16
) (
    input logic      clk,
    input logic      reset,
    cpu_alu_if.slave alu
);
    localparam int MSB = WIDTH - 1;

    logic [MSB:0]   a;
    logic [MSB:0]   b;
    logic [3:0]     shamt;

    logic [MSB:0]   add_b;
    logic           add_cin;
    logic [WIDTH:0] add_ext;
    logic           add_v;
    logic [MSB:0]   sub_x;
    logic [MSB:0]   sub_y;
    logic           sub_cin;
    logic [WIDTH:0] sub_ext;
    logic           sub_v;

    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH:0]     asr_ext;
    logic [2*WIDTH-1:0] rol_ext;

    logic [MSB:0] res;
    logic [MSB:0] alt_src;
    logic [MSB:0] flag_src;
    logic         use_alt;
    logic         c_flag;
    logic         v_flag;

    assign a     = alu.value1;
    assign b     = alu.value2;
    assign shamt = b[3:0];

    // One shared adder (ADD/ADC/INC) and one subtractor (SUB/SBC/CMP/DEC/NEG).
    assign add_b   = alu.single ? {{MSB{1'b0}}, 1'b1} : b;
    assign add_cin = !alu.single && (alu.operator == 4'd8) && alu.carry_in;
    assign add_ext = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_v   = (a[MSB] == add_b[MSB]) && (add_ext[MSB] != a[MSB]);

    assign sub_x   = (alu.single && alu.operator == 4'd2) ? '0 : a;
    assign sub_y   = !alu.single ? b :
                     (alu.operator == 4'd2) ? a : {{MSB{1'b0}}, 1'b1};
    assign sub_cin = !alu.single && (alu.operator == 4'd9) && alu.carry_in;
    assign sub_ext = {1'b0, sub_x} - {1'b0, sub_y} - {{WIDTH{1'b0}}, sub_cin};
    assign sub_v   = (sub_x[MSB] != sub_y[MSB]) && (sub_ext[MSB] != sub_x[MSB]);

    // Extra bit below/above the word catches the last bit shifted out.
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;
    assign asr_ext = $signed({a, 1'b0}) >>> shamt;
    assign rol_ext = {a, a} << shamt;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = a * b;
`endif

    always_comb begin
        res     = a;
        alt_src = '0;
        use_alt = 1'b0;
        c_flag  = 1'b0;
        v_flag  = 1'b0;
        if (!alu.single) begin
            unique case (alu.operator)
                4'd0, 4'd8: begin
                    res    = add_ext[MSB:0];
                    c_flag = add_ext[WIDTH];
                    v_flag = add_v;
                end
                4'd1, 4'd9: begin
                    res    = sub_ext[MSB:0];
                    c_flag = sub_ext[WIDTH];
                    v_flag = sub_v;
                end
                4'd2: res = a & b;
                4'd3: res = a | b;
                4'd4: res = a ^ b;
                4'd5: res = b;
                4'd6: begin
                    alt_src = sub_ext[MSB:0];
                    use_alt = 1'b1;
                    c_flag  = sub_ext[WIDTH];
                    v_flag  = sub_v;
                end
                4'd7: begin
                    alt_src = a & b;
                    use_alt = 1'b1;
                end
`ifdef ALU_MUL_EN
                4'd10: begin
                    res    = prod[MSB:0];
                    c_flag = |prod[2*WIDTH-1:WIDTH];
                    v_flag = |prod[2*WIDTH-1:WIDTH];
                end
                4'd11: res = prod[2*WIDTH-1:WIDTH];
`else
                4'd10, 4'd11: res = '0;
`endif
                4'd12: begin
                    res    = shl_ext[MSB:0];
                    c_flag = shl_ext[WIDTH];
                end
                4'd13: begin
                    res    = shr_ext[WIDTH:1];
                    c_flag = shr_ext[0];
                end
                4'd14: begin
                    res    = asr_ext[WIDTH:1];
                    c_flag = asr_ext[0];
                end
                default: begin
                    res    = rol_ext[2*WIDTH-1:WIDTH];
                    c_flag = (shamt != 4'd0) && rol_ext[WIDTH];
                end
            endcase
        end else begin
            unique case (alu.operator)
                4'd0: begin
                    res    = add_ext[MSB:0];
                    c_flag = add_ext[WIDTH];
                    v_flag = add_v;
                end
                4'd1, 4'd2: begin
                    res    = sub_ext[MSB:0];
                    c_flag = sub_ext[WIDTH];
                    v_flag = sub_v;
                end
                4'd3: res = ~a;
                4'd4: begin
                    res    = {a[MSB-1:0], 1'b0};
                    c_flag = a[MSB];
                end
                4'd5: begin
                    res    = {1'b0, a[MSB:1]};
                    c_flag = a[0];
                end
                4'd6: begin
                    res    = {a[MSB], a[MSB:1]};
                    c_flag = a[0];
                end
                4'd7: begin
                    res    = {a[MSB-1:0], a[MSB]};
                    c_flag = a[MSB];
                end
                4'd8: begin
                    res    = {a[0], a[MSB:1]};
                    c_flag = a[0];
                end
                4'd9:  res = {a[7:0], a[15:8]};
                4'd10: res = {{8{a[7]}}, a[7:0]};
                4'd11: res = {8'h00, a[7:0]};
                4'd12: res = '0;
                default: res = a;
            endcase
        end
        flag_src = use_alt ? alt_src : res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu.bus_out   <= '0;
            alu.alu_flags <= 5'b00000;
        end else begin
            alu.bus_out   <= res;
            alu.alu_flags <= {~^flag_src, v_flag, flag_src[MSB], flag_src == '0, c_flag};
        end
    end
endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu: expectations queued at drive time, checked one clock later.
// Follows ALU_MUL_EN the same way as the design build.
module tb_cpu_alu;
    logic clk;
    logic reset;

    cpu_alu_if #(.WIDTH(16)) bus ();

    cpu_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .alu   (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [15:0] r;
        logic [4:0]  f;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model in integer arithmetic, returns {flags, result}.
    function automatic logic [20:0] model(input bit s, input logic [3:0] op,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input bit ci);
        int          ua, ub, sa, sb, full, sfull, n, cadd;
        longint      prod;
        logic [15:0] r, fsrc;
        bit          c, v, use_fsrc;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n = int'(b[3:0]);
        cadd = int'(ci);
        r = a;
        fsrc = '0;
        c = 0;
        v = 0;
        use_fsrc = 0;
        full = 0;
        sfull = 0;
        prod = 0;
        if (!s) begin
            case (op)
                4'd0, 4'd8: begin
                    if (op == 4'd0) cadd = 0;
                    full = ua + ub + cadd;
                    sfull = sa + sb + cadd;
                    r = 16'(full);
                    c = full > 65535;
                    v = (sfull > 32767) || (sfull < -32768);
                end
                4'd1, 4'd6, 4'd9: begin
                    if (op != 4'd9) cadd = 0;
                    full = ua - ub - cadd;
                    sfull = sa - sb - cadd;
                    r = 16'(full);
                    c = full < 0;
                    v = (sfull > 32767) || (sfull < -32768);
                    if (op == 4'd6) begin
                        fsrc = 16'(full);
                        use_fsrc = 1;
                        r = a;
                    end
                end
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = a ^ b;
                4'd5: r = b;
                4'd7: begin
                    fsrc = a & b;
                    use_fsrc = 1;
                    r = a;
                end
                4'd10, 4'd11: begin
`ifdef ALU_MUL_EN
                    prod = longint'(ua) * longint'(ub);
                    if (op == 4'd10) begin
                        r = 16'(prod);
                        c = (prod >> 16) != 0;
                        v = c;
                    end else begin
                        r = 16'(prod >> 16);
                    end
`else
                    r = 16'h0000;
`endif
                end
                4'd12: for (int i = 0; i < n; i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
                4'd13: for (int i = 0; i < n; i++) begin c = r[0]; r = {1'b0, r[15:1]}; end
                4'd14: for (int i = 0; i < n; i++) begin c = r[0]; r = {r[15], r[15:1]}; end
                default: begin
                    for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
                    c = (n != 0) && r[0];
                end
            endcase
        end else begin
            case (op)
                4'd0: begin full = ua + 1; r = 16'(full); c = full > 65535; v = (sa + 1) > 32767; end
                4'd1: begin full = ua - 1; r = 16'(full); c = full < 0; v = (sa - 1) < -32768; end
                4'd2: begin full = -ua; r = 16'(full); c = ua != 0; v = (-sa) > 32767; end
                4'd3: r = ~a;
                4'd4: begin c = a[15]; r = a << 1; end
                4'd5: begin c = a[0]; r = a >> 1; end
                4'd6: begin c = a[0]; r = 16'($signed(a) >>> 1); end
                4'd7: begin c = a[15]; r = {a[14:0], a[15]}; end
                4'd8: begin c = a[0]; r = {a[0], a[15:1]}; end
                4'd9: r = {a[7:0], a[15:8]};
                4'd10: r = 16'($signed(a[7:0]));
                4'd11: r = {8'h00, a[7:0]};
                4'd12: r = 16'h0000;
                default: r = a;
            endcase
        end
        if (!use_fsrc) fsrc = r;
        return {~^fsrc, v, fsrc[15], fsrc == 16'h0000, c, r};
    endfunction

    task automatic drive(input bit rst, input bit s, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input bit ci);
        @(negedge clk);
        reset = rst;
        bus.single = s;
        bus.operator = op;
        bus.value1 = a;
        bus.value2 = b;
        bus.carry_in = ci;
    endtask

    task automatic send(input string tag, input bit s, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input bit ci);
        logic [20:0] m;
        drive(1'b0, s, op, a, b, ci);
        m = model(s, op, a, b, ci);
        q.push_back('{tag, m[15:0], m[20:16]});
    endtask

    task automatic send_exp(input string tag, input bit rst, input bit s, input logic [3:0] op,
                            input logic [15:0] a, input logic [15:0] b, input bit ci,
                            input logic [15:0] er, input logic [4:0] ef);
        drive(rst, s, op, a, b, ci);
        q.push_back('{tag, er, ef});
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, "_res"}, bus.bus_out, e.r);
            chk({e.tag, "_flg"}, {11'd0, bus.alu_flags}, {11'd0, e.f});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.single = 1'b0;
        bus.operator = 4'd0;
        bus.value1 = '0;
        bus.value2 = '0;
        bus.carry_in = 1'b0;

        send_exp("reset", 1, 0, 4'd0, 16'h5555, 16'h1111, 0, 16'h0000, 5'b00000);
        send_exp("add_wrap", 0, 0, 4'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 5'b10011);
        send_exp("sub_ovf", 0, 0, 4'd1, 16'h8000, 16'h0001, 0, 16'h7FFF, 5'b01000);
        send_exp("inc_ovf", 0, 1, 4'd0, 16'h7FFF, 16'h0000, 0, 16'h8000, 5'b01100);
        send_exp("shr1", 0, 1, 4'd5, 16'h0003, 16'h0000, 0, 16'h0001, 5'b00001);
`ifdef ALU_MUL_EN
        send_exp("mul", 0, 0, 4'd10, 16'h0100, 16'h0100, 0, 16'h0000, 5'b11011);
        send_exp("mulh", 0, 0, 4'd11, 16'h0100, 16'h0100, 0, 16'h0001, 5'b00000);
`else
        send_exp("mul_off", 0, 0, 4'd10, 16'h0100, 16'h0100, 0, 16'h0000, 5'b10010);
        send_exp("mulh_off", 0, 0, 4'd11, 16'h0100, 16'h0100, 0, 16'h0000, 5'b10010);
`endif
        send_exp("shl0", 0, 0, 4'd12, 16'h8001, 16'h0000, 0, 16'h8001, 5'b10100);
        send_exp("shl1", 0, 0, 4'd12, 16'h8001, 16'h0001, 0, 16'h0002, 5'b00001);
        send_exp("asr15", 0, 0, 4'd14, 16'h8000, 16'h000F, 0, 16'hFFFF, 5'b10100);
        send_exp("rol1", 0, 0, 4'd15, 16'h8001, 16'h0001, 0, 16'h0003, 5'b10001);
        send_exp("neg_min", 0, 1, 4'd2, 16'h8000, 16'h0000, 0, 16'h8000, 5'b01101);
        send_exp("cmp_eq", 0, 0, 4'd6, 16'h5555, 16'h5555, 0, 16'h5555, 5'b10010);
        send_exp("sbc_cin", 0, 0, 4'd9, 16'h0000, 16'h0000, 1, 16'hFFFF, 5'b10101);
        send_exp("rst_prio", 1, 0, 4'd0, 16'h1234, 16'h1111, 0, 16'h0000, 5'b00000);
        send_exp("post_rst", 0, 0, 4'd0, 16'h1234, 16'h1111, 0, 16'h2345, 5'b10000);

        for (int op = 0; op < 16; op++) begin
            send("two_edge", 0, 4'(op), 16'h8000, 16'h7FFF, 1);
            send("one_edge", 1, 4'(op), 16'hFF80, 16'h0000, 0);
            send("one_zero", 1, 4'(op), 16'h0000, 16'h0000, 0);
        end
        for (int i = 0; i < 300; i++) begin
            send("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("drain", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
